mem_arbiter_ctrl: RTL and testbench

- Sequences the single byte-wide RAM port and shares it between instruction fetch (IF) and the MEM stage (load/store).
- Grants one requester per transaction.
- Splits 8/16/32-bit accesses into byte beats and assembles or scatters data little-endian.
- Returns a one-cycle done pulse to the granted requester; the pipeline stalls on the requester side until done.

---
 rtl/mem_arbiter_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: shares one byte-wide RAM port between instruction fetch
// and the MEM stage. Multi-byte accesses are split into byte beats, and
// data is assembled or scattered little-endian. The granted requester gets
// a one-cycle done pulse.
module mem_arbiter_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic              if_done_out,
  output logic [31:0]       if_inst_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [1:0]        mem_len_in,
  input  logic [31:0]       mem_wdata_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  output logic              ram_rw_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy_out
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic [2:0]        len_dec;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_merged;
  logic [7:0]        wbyte;

  // Decode the MEM length code into a byte count; code 10 behaves like 4 bytes.
  always_comb begin
    len_dec = 3'd4;
    case (mem_len_in)
      2'b00:   len_dec = 3'd1;
      2'b01:   len_dec = 3'd2;
      default: len_dec = 3'd4;
    endcase
  end

  // Merge the byte arriving on ram_din into the assembly word.
  // cnt counts edges since acceptance, and byte cnt-2 is on ram_din now.
  always_comb begin
    byte_idx   = 2'(cnt - 3'd2);
    asm_merged = asm_q;
    asm_merged[{byte_idx, 3'b000} +: 8] = ram_din;
  end

  // Select the store byte for the beat issued at the current edge.
  always_comb begin
    wbyte = wdata_q[{cnt[1:0], 3'b000} +: 8];
  end

  // Arbitration, beat sequencing and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      asm_q         <= '0;
      if_done_out   <= 1'b0;
      if_inst_out   <= '0;
      mem_done_out  <= 1'b0;
      mem_rdata_out <= '0;
      ram_rw_out    <= 1'b0;
      ram_addr_out  <= '0;
      ram_dout      <= '0;
      busy_out      <= 1'b0;
    end else begin
      if_done_out  <= 1'b0;
      mem_done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_in) begin
            addr_q       <= mem_addr_in;
            len_q        <= len_dec;
            wdata_q      <= mem_wdata_in;
            asm_q        <= '0;
            cnt          <= 3'd1;
            ram_addr_out <= mem_addr_in;
            busy_out     <= 1'b1;
            if (mem_we_in) begin
              state      <= MEM_WR;
              ram_rw_out <= 1'b1;
              ram_dout   <= mem_wdata_in[7:0];
            end else begin
              state      <= MEM_RD;
              ram_rw_out <= 1'b0;
            end
          end else if (if_req_in && !if_flush_in) begin
            state        <= IF_RD;
            addr_q       <= if_addr_in;
            len_q        <= 3'd4;
            asm_q        <= '0;
            cnt          <= 3'd1;
            ram_addr_out <= if_addr_in;
            ram_rw_out   <= 1'b0;
            busy_out     <= 1'b1;
          end else begin
            ram_addr_out <= '0;
            ram_rw_out   <= 1'b0;
            busy_out     <= 1'b0;
          end
        end

        IF_RD, MEM_RD: begin
          if (state == IF_RD && if_flush_in) begin
            state        <= IDLE;
            cnt          <= '0;
            ram_addr_out <= '0;
            busy_out     <= 1'b0;
          end else if (cnt == len_q + 3'd1) begin
            // The last byte is on ram_din at this edge, so it is merged straight into the output.
            state        <= IDLE;
            cnt          <= '0;
            ram_addr_out <= '0;
            busy_out     <= 1'b0;
            if (state == IF_RD) begin
              if_done_out <= 1'b1;
              if_inst_out <= asm_merged;
            end else begin
              mem_done_out  <= 1'b1;
              mem_rdata_out <= asm_merged;
            end
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt >= 3'd2) asm_q <= asm_merged;
            if (cnt < len_q) ram_addr_out <= addr_q + ADDR_W'(cnt);
          end
        end

        MEM_WR: begin
          if (cnt == len_q) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_done_out <= 1'b1;
            ram_rw_out   <= 1'b0;
            ram_addr_out <= '0;
            ram_dout     <= '0;
            busy_out     <= 1'b0;
          end else begin
            cnt          <= cnt + 3'd1;
            ram_rw_out   <= 1'b1;
            ram_addr_out <= addr_q + ADDR_W'(cnt);
            ram_dout     <= wbyte;
          end
        end

        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed testbench for mem_arbiter_ctrl with a byte-wide RAM model.
module tb_mem_arbiter_ctrl;

  localparam int unsigned ADDR_W = 32;

  logic              clk_in;
  logic              rst_in;
  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_flush_in;
  logic              if_done_out;
  logic [31:0]       if_inst_out;
  logic              mem_req_in;
  logic              mem_we_in;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [1:0]        mem_len_in;
  logic [31:0]       mem_wdata_in;
  logic              mem_done_out;
  logic [31:0]       mem_rdata_out;
  logic              ram_rw_out;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit [7:0] wr_mem [bit [31:0]];

  mem_arbiter_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .if_req_in    (if_req_in),
    .if_addr_in   (if_addr_in),
    .if_flush_in  (if_flush_in),
    .if_done_out  (if_done_out),
    .if_inst_out  (if_inst_out),
    .mem_req_in   (mem_req_in),
    .mem_we_in    (mem_we_in),
    .mem_addr_in  (mem_addr_in),
    .mem_len_in   (mem_len_in),
    .mem_wdata_in (mem_wdata_in),
    .mem_done_out (mem_done_out),
    .mem_rdata_out(mem_rdata_out),
    .ram_rw_out   (ram_rw_out),
    .ram_addr_out (ram_addr_out),
    .ram_dout     (ram_dout),
    .ram_din      (ram_din),
    .busy_out     (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Preloaded RAM contents; any address not listed reads 0.
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: rom_byte = 8'h13;
      32'h0000_0101: rom_byte = 8'h05;
      32'h0000_0102: rom_byte = 8'hA0;
      32'h0000_0103: rom_byte = 8'h00;
      32'h0000_0104: rom_byte = 8'h11;
      32'h0000_0105: rom_byte = 8'h22;
      32'h0000_0106: rom_byte = 8'h33;
      32'h0000_0107: rom_byte = 8'h44;
      32'h0000_0200: rom_byte = 8'hFE;
      32'h0000_0201: rom_byte = 8'h07;
      32'h0000_0302: rom_byte = 8'h5A;
      32'hFFFF_FFFE: rom_byte = 8'hA1;
      32'hFFFF_FFFF: rom_byte = 8'hB2;
      32'h0000_0000: rom_byte = 8'hC3;
      32'h0000_0001: rom_byte = 8'hD4;
      default:       rom_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (wr_mem.exists(a)) mem_byte = wr_mem[a];
    else                  mem_byte = rom_byte(a);
  endfunction

  // RAM model: read data appears one cycle after its address, and writes land at the edge.
  always @(posedge clk_in) begin
    ram_din <= mem_byte(ram_addr_out);
    if (ram_rw_out) wr_mem[ram_addr_out] = ram_dout;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in       = 1'b0;
    if_req_in    = 1'b1;
    if_addr_in   = 32'h0000_0100;
    if_flush_in  = 1'b0;
    mem_req_in   = 1'b0;
    mem_we_in    = 1'b0;
    mem_addr_in  = '0;
    mem_len_in   = 2'b00;
    mem_wdata_in = '0;

    // Reset held for two edges with a fetch request pending
    tick(); tick();
    check("rst_busy",   32'(busy_out), 32'd0);
    check("rst_ifdone", 32'(if_done_out), 32'd0);
    check("rst_memdone",32'(mem_done_out), 32'd0);
    check("rst_rw",     32'(ram_rw_out), 32'd0);
    check("rst_addr",   ram_addr_out, 32'h0);
    check("rst_dout",   32'(ram_dout), 32'h0);
    check("rst_inst",   if_inst_out, 32'h0);
    check("rst_rdata",  mem_rdata_out, 32'h0);

    // Fetch from 0x100, accepted at the first edge after reset is released
    rst_in = 1'b1;
    tick();
    check("if_busy", 32'(busy_out), 32'd1);
    check("if_a0",   ram_addr_out, 32'h100);
    check("if_rw0",  32'(ram_rw_out), 32'd0);
    tick(); check("if_a1", ram_addr_out, 32'h101);
    tick(); check("if_a2", ram_addr_out, 32'h102);
    tick(); check("if_a3", ram_addr_out, 32'h103);
    tick(); check("if_nodone4", 32'(if_done_out), 32'd0);
    check("if_busy4", 32'(busy_out), 32'd1);
    tick();
    check("if_done", 32'(if_done_out), 32'd1);
    check("if_inst", if_inst_out, 32'h00A0_0513);
    check("if_idle_busy", 32'(busy_out), 32'd0);
    if_req_in = 1'b0;
    tick();
    check("if_done_pulse", 32'(if_done_out), 32'd0);

    // Simultaneous requests: the MEM byte load is served first, then IF with no bubble
    if_req_in   = 1'b1;
    if_addr_in  = 32'h0000_0104;
    mem_req_in  = 1'b1;
    mem_we_in   = 1'b0;
    mem_len_in  = 2'b00;
    mem_addr_in = 32'h0000_0200;
    tick();
    check("sim_mem_addr", ram_addr_out, 32'h200);
    tick(); check("sim_nodone", 32'(mem_done_out), 32'd0);
    tick();
    check("sim_memdone", 32'(mem_done_out), 32'd1);
    check("sim_rdata",   mem_rdata_out, 32'h0000_00FE);
    check("sim_ifwait",  32'(if_done_out), 32'd0);
    mem_req_in = 1'b0;
    tick();
    check("sim_if_addr",   ram_addr_out, 32'h104);
    check("sim_if_busy",   32'(busy_out), 32'd1);
    check("sim_memdone_0", 32'(mem_done_out), 32'd0);
    tick(); tick(); tick(); tick();
    check("sim_if_nodone", 32'(if_done_out), 32'd0);
    tick();
    check("sim_if_done", 32'(if_done_out), 32'd1);
    check("sim_if_inst", if_inst_out, 32'h4433_2211);
    check("sim_rdata_hold", mem_rdata_out, 32'h0000_00FE);
    if_req_in = 1'b0;

    // Halfword store to 0x300
    mem_req_in   = 1'b1;
    mem_we_in    = 1'b1;
    mem_len_in   = 2'b01;
    mem_addr_in  = 32'h0000_0300;
    mem_wdata_in = 32'hDEAD_BEEF;
    tick();
    check("st_rw0",   32'(ram_rw_out), 32'd1);
    check("st_a0",    ram_addr_out, 32'h300);
    check("st_d0",    32'(ram_dout), 32'hEF);
    tick();
    check("st_rw1",   32'(ram_rw_out), 32'd1);
    check("st_a1",    ram_addr_out, 32'h301);
    check("st_d1",    32'(ram_dout), 32'hBE);
    tick();
    check("st_done",  32'(mem_done_out), 32'd1);
    check("st_rw_end",32'(ram_rw_out), 32'd0);
    mem_req_in = 1'b0;
    mem_we_in  = 1'b0;
    tick();
    check("st_ram300", 32'(mem_byte(32'h300)), 32'hEF);
    check("st_ram301", 32'(mem_byte(32'h301)), 32'hBE);
    check("st_ram302", 32'(mem_byte(32'h302)), 32'h5A);
    check("st_done_pulse", 32'(mem_done_out), 32'd0);

    // Flush while idle blocks the IF grant
    if_req_in   = 1'b1;
    if_addr_in  = 32'h0000_0400;
    if_flush_in = 1'b1;
    tick();
    check("fl_idle_busy", 32'(busy_out), 32'd0);
    if_flush_in = 1'b0;

    // Flush after two fetch beats, with a MEM halfword load pending
    tick(); check("fl_a0", ram_addr_out, 32'h400);
    tick(); check("fl_a1", ram_addr_out, 32'h401);
    if_flush_in = 1'b1;
    mem_req_in  = 1'b1;
    mem_we_in   = 1'b0;
    mem_len_in  = 2'b01;
    mem_addr_in = 32'h0000_0200;
    tick();
    check("fl_busy",   32'(busy_out), 32'd0);
    check("fl_nodone", 32'(if_done_out), 32'd0);
    check("fl_addr0",  ram_addr_out, 32'h0);
    if_flush_in = 1'b0;
    if_req_in   = 1'b0;
    tick();
    check("fl_mem_a0",   ram_addr_out, 32'h200);
    check("fl_mem_busy", 32'(busy_out), 32'd1);
    tick(); check("fl_mem_a1", ram_addr_out, 32'h201);
    tick(); check("fl_mem_nodone", 32'(mem_done_out), 32'd0);
    tick();
    check("fl_mem_done",  32'(mem_done_out), 32'd1);
    check("fl_mem_rdata", mem_rdata_out, 32'h0000_07FE);
    check("fl_inst_hold", if_inst_out, 32'h4433_2211);
    mem_req_in = 1'b0;

    // Word load across the top of the address space
    mem_req_in  = 1'b1;
    mem_len_in  = 2'b11;
    mem_addr_in = 32'hFFFF_FFFE;
    tick(); check("wr_a0", ram_addr_out, 32'hFFFF_FFFE);
    tick(); check("wr_a1", ram_addr_out, 32'hFFFF_FFFF);
    tick(); check("wr_a2", ram_addr_out, 32'h0000_0000);
    tick(); check("wr_a3", ram_addr_out, 32'h0000_0001);
    tick(); check("wr_nodone", 32'(mem_done_out), 32'd0);
    tick();
    check("wr_done",  32'(mem_done_out), 32'd1);
    check("wr_rdata", mem_rdata_out, 32'hD4C3_B2A1);
    mem_req_in = 1'b0;
    tick();

    // Length code 10 reads four bytes
    mem_req_in  = 1'b1;
    mem_len_in  = 2'b10;
    mem_addr_in = 32'h0000_0104;
    tick(); tick(); tick(); tick(); tick();
    check("l10_nodone", 32'(mem_done_out), 32'd0);
    tick();
    check("l10_done",  32'(mem_done_out), 32'd1);
    check("l10_rdata", mem_rdata_out, 32'h4433_2211);
    mem_req_in = 1'b0;
    tick();

    // Reset mid-transaction drops it with no done pulse
    mem_req_in  = 1'b1;
    mem_len_in  = 2'b11;
    mem_addr_in = 32'h0000_0100;
    tick(); tick();
    rst_in = 1'b0;
    tick();
    check("mrst_busy",  32'(busy_out), 32'd0);
    check("mrst_addr",  ram_addr_out, 32'h0);
    check("mrst_rdata", mem_rdata_out, 32'h0);
    mem_req_in = 1'b0;
    rst_in     = 1'b1;
    tick(); tick(); tick(); tick();
    check("mrst_nodone", 32'(mem_done_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
